// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared cause codes, Status bit indices and sequencer state type
//
// Used by exc_ctrl and its interface. The cause codes match the encoding
// that CP0 expects in its Cause.ExcCode field.
package mips_pkg;

    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;
    localparam logic [4:0] CAUSE_INT     = 5'b00000;

    // Status register bit positions
    localparam int ST_IE      = 0;
    localparam int ST_SYSCALL = 1;
    localparam int ST_BREAK   = 2;
    localparam int ST_TEQ     = 3;
    localparam int ST_IM0     = 8;   // interrupt mask for ext_irq[0]; lines 1..5 follow

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTER    = 3'd1,
        S_RETURN   = 3'd2,
        S_REDIRECT = 3'd3,
        S_FLUSH    = 3'd4
    } exc_state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - decode/CP0/PC-side signal bundle of the exception sequencer
//
// master : the sequencer (exc_ctrl) - takes requests, drives CP0 strobes and PC control
// slave  : the surrounding decode/CP0/PC logic
// Optional: EXC_EXT_IRQ_EN adds the 6-bit ext_irq input.
interface exc_ctrl_if;
    logic        syscall_req;
    logic        break_req;
    logic        teq_req;
    logic        teq_eq;
    logic        eret_req;
    logic [31:0] inst_pc;
    logic [31:0] status;
    logic [31:0] exc_addr;
`ifdef EXC_EXT_IRQ_EN
    logic [5:0]  ext_irq;
`endif
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        stall;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        flush;
    logic        busy;

    modport master (
`ifdef EXC_EXT_IRQ_EN
        input  ext_irq,
`endif
        input  syscall_req, break_req, teq_req, teq_eq, eret_req,
        input  inst_pc, status, exc_addr,
        output exception, eret, cause, epc, stall, pc_load, pc_target, flush, busy
    );

    modport slave (
`ifdef EXC_EXT_IRQ_EN
        output ext_irq,
`endif
        output syscall_req, break_req, teq_req, teq_eq, eret_req,
        output inst_pc, status, exc_addr,
        input  exception, eret, cause, epc, stall, pc_load, pc_target, flush, busy
    );
endinterface

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - 6-bit two-flop synchronizer with rising-edge detect
//
// Present only when EXC_EXT_IRQ_EN is defined.
// Ports: i_clk, i_rst_n (async, active-low), i_irq[5:0] async lines,
//        o_rise[5:0] one-cycle pulse per synchronized rising edge.
`ifdef EXC_EXT_IRQ_EN
module irq_sync (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_irq,
    output logic [5:0] o_rise
);
    logic [5:0] r_meta;
    logic [5:0] r_sync;
    logic [5:0] r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
endmodule
`endif

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/ERET sequencer driving the CP0 exception interface
//
// Ports: i_clk, i_rst_n (async, active-low), bus (exc_ctrl_if.master: trap/ERET
//        requests in, CP0 strobes + PC stall/redirect/flush out),
//        o_vector_ok (high in ENTER when exc_addr equals VECTOR).
// Optional: EXC_EXT_IRQ_EN enables external interrupt entry via irq_sync.
module exc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] VECTOR       = 32'h0000_0004
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    exc_ctrl_if.master  bus,
    output logic        o_vector_ok
);
    exc_state_t  r_state;
    exc_state_t  w_next;
    logic [3:0]  r_cnt;
    logic [4:0]  r_cause;
    logic [31:0] r_epc;
    logic        r_exception;
    logic        r_eret;

    logic        w_ie;
    logic        w_sys;
    logic        w_brk;
    logic        w_teq;
    logic        w_trap;
    logic        w_irq;
    logic [4:0]  w_cause_sel;
    logic        w_stall;
    logic        w_pc_load;
    logic        w_flush;
    logic        w_unused_status;

    assign w_ie   = bus.status[ST_IE];
    assign w_sys  = bus.syscall_req & w_ie & bus.status[ST_SYSCALL];
    assign w_brk  = bus.break_req   & w_ie & bus.status[ST_BREAK];
    assign w_teq  = bus.teq_req & bus.teq_eq & w_ie & bus.status[ST_TEQ];
    assign w_trap = w_sys | w_brk | w_teq;

`ifdef EXC_EXT_IRQ_EN
    logic [5:0] w_irq_rise;
    logic [5:0] w_irq_act;
    logic [5:0] w_irq_clr;
    logic [2:0] w_irq_idx;
    logic       w_irq_start;
    logic [5:0] r_pending;
    logic [2:0] r_irq_idx;
    logic       r_irq_taken;

    irq_sync u_irq_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_irq   (bus.ext_irq),
        .o_rise  (w_irq_rise)
    );

    // A fresh edge counts in the same cycle it is detected, saving one cycle of latency.
    assign w_irq_act = (r_pending | w_irq_rise) & bus.status[ST_IM0 +: 6] & {6{w_ie}};
    assign w_irq     = |w_irq_act;

    always_comb begin
        w_irq_idx = '0;
        for (int i = 5; i >= 0; i--) begin
            if (w_irq_act[i]) w_irq_idx = 3'(i);
        end
    end

    // Interrupts have the lowest priority: only taken when nothing else enters.
    assign w_irq_start = (r_state == S_IDLE) && !w_trap && !bus.eret_req && w_irq;
    assign w_irq_clr   = (r_state == S_ENTER && r_irq_taken) ? (6'(1) << r_irq_idx) : 6'(0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending   <= '0;
            r_irq_idx   <= '0;
            r_irq_taken <= 1'b0;
        end else begin
            // New edges win over a clear of the same bit so no edge is lost.
            r_pending   <= (r_pending & ~w_irq_clr) | w_irq_rise;
            r_irq_taken <= w_irq_start;
            if (w_irq_start) r_irq_idx <= w_irq_idx;
        end
    end

    assign w_unused_status = ^{bus.status[31:14], bus.status[7:4]};
`else
    assign w_irq           = 1'b0;
    assign w_unused_status = ^bus.status[31:4];
`endif

    always_comb begin
        w_cause_sel = CAUSE_INT;
        if (w_sys)      w_cause_sel = CAUSE_SYSCALL;
        else if (w_brk) w_cause_sel = CAUSE_BREAK;
        else if (w_teq) w_cause_sel = CAUSE_TEQ;
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trap)            w_next = S_ENTER;
                else if (bus.eret_req) w_next = S_RETURN;
                else if (w_irq)        w_next = S_ENTER;
            end
            S_ENTER, S_RETURN: w_next = S_REDIRECT;
            S_REDIRECT:        w_next = S_FLUSH;
            S_FLUSH:           if (r_cnt == 4'd0) w_next = S_IDLE;
            default:           w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_stall   = 1'b0;
        w_pc_load = 1'b0;
        w_flush   = 1'b0;
        case (r_state)
            S_ENTER, S_RETURN: begin
                w_stall   = 1'b1;
                w_pc_load = 1'b1;
            end
            S_REDIRECT, S_FLUSH: w_flush = 1'b1;
            default: ;
        endcase
    end

    // CP0 strobes are flopped from the next state so they are clean through the
    // CP0 negedge commit; cause/epc only change on entry, never on ERET.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exception <= 1'b0;
            r_eret      <= 1'b0;
            r_cause     <= '0;
            r_epc       <= '0;
            r_cnt       <= '0;
        end else begin
            r_exception <= (w_next == S_ENTER) || (w_next == S_RETURN);
            r_eret      <= (w_next == S_RETURN);
            if (r_state == S_IDLE && w_next == S_ENTER) begin
                r_cause <= w_cause_sel;
                r_epc   <= bus.inst_pc;
            end
            if (r_state == S_REDIRECT)                r_cnt <= 4'(FLUSH_CYCLES - 1);
            else if (r_state == S_FLUSH && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
        end
    end

    assign bus.exception = r_exception;
    assign bus.eret      = r_eret;
    assign bus.cause     = r_cause;
    assign bus.epc       = r_epc;
    assign bus.stall     = w_stall;
    assign bus.pc_load   = w_pc_load;
    assign bus.pc_target = w_pc_load ? bus.exc_addr : 32'd0;
    assign bus.flush     = w_flush;
    assign bus.busy      = (r_state != S_IDLE);
    assign o_vector_ok   = (r_state == S_ENTER) && (bus.exc_addr == VECTOR);

endmodule
